div_issue_arbiter: RTL and testbench
====================================

Name: div_issue_arbiter

Overview:
- Front end of the shared divide/remainder unit. Collects DIV/DIVU/REM/REMU requests from up to 4 cores.
- Holds one request per core and picks one per cycle by round-robin. Drives the divider's single request/core_num/order/rs1/rs2 input port.
- Tracks each core's in-flight operation until the divider's per-core ready pulse returns. This guarantees at most one outstanding operation per core, so ans_N is never overwritten.

Parameters:
- NUM_CORES, 4, number of requesting cores; fixed at 4 to match the divider's 4 result ports.
- TIMEOUT, 31, cycles an issued operation may wait for its ready pulse before being abandoned; range 12..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- core_req  input  4  bit n: core n presents a divide op this cycle.
- core_order  input  8  2 bits per core, [2n+1:2n]. bit1 = 1 for remainder, 0 for divide; bit0 = 1 for unsigned, 0 for signed.
- core_rs1  input  128  32-bit dividend per core, [32n+31:32n].
- core_rs2  input  128  32-bit divisor per core, [32n+31:32n].
- core_ack  output  4  bit n: core n's request is accepted this cycle (combinational).
- core_busy  output  4  bit n: core n has a request held or in flight.
- div_ready  input  4  divider's ready_0..ready_3 pulses.
- request  output  1  issue strobe to the divider, one cycle per op.
- core_num  output  3  issuing core id; bit2 is always 0.
- order  output  2  op code of the issued op.
- rs1  output  32  dividend of the issued op.
- rs2  output  32  divisor of the issued op.
- timeout_err  output  4  sticky per-core flag: an op was abandoned after TIMEOUT cycles.

Behaviour:
- Per-core FSM with three states:
  - IDLE -> HELD when core_req[n] and core_ack[n]. The entry latches order/rs1/rs2 at that edge.
  - HELD -> ISSUED on the edge where core n wins arbitration.
  - ISSUED -> IDLE when div_ready[n]=1, or when the age counter reaches TIMEOUT. On timeout, timeout_err[n] is set as well.
- core_ack[n] = core_req[n] & (state==IDLE). A core must hold its request until acked.
- core_busy[n] = (state != IDLE).
- Arbitration:
  - Each cycle, among HELD entries, grant the first one found searching from rr_ptr+1 upward, mod 4.
  - The rr_ptr register updates to the granted index on the grant edge; it holds when there is no grant.
- Issue outputs are registered:
  - On a grant edge: request<=1; core_num<={1'b0,n}; order/rs1/rs2 <= entry n.
  - Otherwise request<=0, and order/rs1/rs2/core_num hold their last values.
  - request is never high on two consecutive cycles for the same op.
- Latency: a core_req accepted at edge t with no contention gives HELD after t, grant at edge t+1, and request high during cycle t+1..t+2.
  - With 4 contending cores, the worst-case wait is 3 extra cycles.
  - Back-to-back issues from different cores are allowed every cycle.
- Age counter: 8 bits per core. Cleared on entry to ISSUED, increments each cycle while ISSUED, and saturates at TIMEOUT.
- Simultaneous events:
  - div_ready[n] and core_req[n] in the same cycle: the slot returns to IDLE at that edge. core_ack[n] is 0 in that cycle, so the new request is accepted the next cycle.
  - div_ready[n] arriving while core n is IDLE or HELD is ignored; the FSM does not change.
  - div_ready arriving on the same edge as timeout is treated as a normal completion, and timeout_err is not set.
- Reset, asserted at any time:
  - All FSMs go to IDLE, rr_ptr=3 so core 0 has first priority, and all age counters are 0.
  - request=0, core_num=0, order=0, rs1=0, rs2=0, timeout_err=0.
  - Held and in-flight ops are dropped; any later div_ready pulses are ignored under the IDLE rule.
- timeout_err bits are cleared only by reset.

Test Plan:
- Single op: core 2 requests order=2'b00, rs1=100, rs2=7. Expect core_ack[2]=1 for one cycle, then request=1 for one cycle with core_num=3'b010, rs1=100, rs2=7. core_busy[2] stays 1 until a div_ready[2] pulse, then drops on the next edge.
- Contention: all 4 cores request in the same cycle after reset. Expect issues in order 0,1,2,3 on consecutive cycles, request high for 4 cycles. A refill of core 0 while core 3 is still HELD issues after core 3.
- One-outstanding rule: core 1 requests again while ISSUED. core_ack[1] must stay 0 and no second issue for core 1 until div_ready[1]. With div_ready[1] and core_req[1] in the same cycle, the ack comes one cycle later.
- Timeout: with TIMEOUT=31, issue core 3 and never pulse div_ready[3]. After 31 cycles in ISSUED, core_busy[3]=0 and timeout_err[3]=1 (sticky). A later div_ready[3] leaves the FSM unchanged.
- Reset mid-operation: cores 0 and 2 HELD or ISSUED when reset pulses high. Outputs go to their reset values immediately without waiting for clk, and the first post-reset grant goes to core 0.

Source files
------------

// File: rtl/div_issue_arbiter.sv
// Issue arbiter in front of the shared divide/remainder unit: one held op per core,
// round-robin issue, and per-core in-flight tracking until the divider's ready pulse or a timeout.
module div_issue_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT   = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    core_req,
    input  logic [2*NUM_CORES-1:0]  core_order,
    input  logic [32*NUM_CORES-1:0] core_rs1,
    input  logic [32*NUM_CORES-1:0] core_rs2,
    output logic [NUM_CORES-1:0]    core_ack,
    output logic [NUM_CORES-1:0]    core_busy,
    input  logic [NUM_CORES-1:0]    div_ready,
    output logic                    request,
    output logic [2:0]              core_num,
    output logic [1:0]              order,
    output logic [31:0]             rs1,
    output logic [31:0]             rs2,
    output logic [NUM_CORES-1:0]    timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_ISSUED = 2'd2
    } state_e;

    state_e         state_q [NUM_CORES];
    logic [1:0]     ord_q   [NUM_CORES];
    logic [31:0]    a_q     [NUM_CORES];
    logic [31:0]    b_q     [NUM_CORES];
    logic [7:0]     age_q   [NUM_CORES];
    logic [1:0]     rr_ptr_q;
    logic           request_q;
    logic [2:0]     core_num_q;
    logic [1:0]     order_q;
    logic [31:0]    rs1_q;
    logic [31:0]    rs2_q;
    logic [NUM_CORES-1:0] err_q;

    logic           grant_vld_s;
    logic [1:0]     grant_idx_s;
    logic [1:0]     cand_s;

    // Round-robin pick among held entries, starting just after the last winner.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = 2'd0;
        cand_s      = 2'd0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand_s = rr_ptr_q + 2'(k);
            if (!grant_vld_s && state_q[cand_s] == ST_HELD) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Per-core acknowledge and busy status decoded from the slot state.
    always_comb begin
        core_ack  = '0;
        core_busy = '0;
        for (int n = 0; n < NUM_CORES; n++) begin
            core_ack[n]  = core_req[n] & (state_q[n] == ST_IDLE);
            core_busy[n] = (state_q[n] != ST_IDLE);
        end
    end

    // Slot FSMs, age counters, round-robin pointer and registered issue port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= 2'd3;
            request_q  <= 1'b0;
            core_num_q <= 3'd0;
            order_q    <= 2'd0;
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            err_q      <= '0;
            for (int n = 0; n < NUM_CORES; n++) begin
                state_q[n] <= ST_IDLE;
                ord_q[n]   <= 2'd0;
                a_q[n]     <= 32'd0;
                b_q[n]     <= 32'd0;
                age_q[n]   <= 8'd0;
            end
        end else begin
            request_q <= grant_vld_s;
            if (grant_vld_s) begin
                rr_ptr_q   <= grant_idx_s;
                core_num_q <= {1'b0, grant_idx_s};
                order_q    <= ord_q[grant_idx_s];
                rs1_q      <= a_q[grant_idx_s];
                rs2_q      <= b_q[grant_idx_s];
            end
            for (int n = 0; n < NUM_CORES; n++) begin
                case (state_q[n])
                    ST_IDLE: begin
                        if (core_req[n]) begin
                            state_q[n] <= ST_HELD;
                            ord_q[n]   <= core_order[2*n +: 2];
                            a_q[n]     <= core_rs1[32*n +: 32];
                            b_q[n]     <= core_rs2[32*n +: 32];
                        end
                    end
                    ST_HELD: begin
                        if (grant_vld_s && grant_idx_s == 2'(n)) begin
                            state_q[n] <= ST_ISSUED;
                            age_q[n]   <= 8'd0;
                        end
                    end
                    ST_ISSUED: begin
                        // A ready pulse on the timeout edge still counts as a normal completion.
                        if (div_ready[n]) begin
                            state_q[n] <= ST_IDLE;
                        end else if (age_q[n] == 8'(TIMEOUT)) begin
                            state_q[n] <= ST_IDLE;
                            err_q[n]   <= 1'b1;
                        end else begin
                            age_q[n]   <= age_q[n] + 8'd1;
                        end
                    end
                    default: state_q[n] <= ST_IDLE;
                endcase
            end
        end
    end

    assign request     = request_q;
    assign core_num    = core_num_q;
    assign order       = order_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Directed bench for div_issue_arbiter: single op, contention, one-outstanding rule,
// timeout and asynchronous reset mid-operation.
module tb_div_issue_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   core_req;
    logic [7:0]   core_order;
    logic [127:0] core_rs1;
    logic [127:0] core_rs2;
    logic [3:0]   core_ack;
    logic [3:0]   core_busy;
    logic [3:0]   div_ready;
    logic         request;
    logic [2:0]   core_num;
    logic [1:0]   order;
    logic [31:0]  rs1;
    logic [31:0]  rs2;
    logic [3:0]   timeout_err;

    int pass_cnt;
    int total_cnt;

    div_issue_arbiter #(.NUM_CORES(4), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_order(core_order),
        .core_rs1(core_rs1), .core_rs2(core_rs2), .core_ack(core_ack),
        .core_busy(core_busy), .div_ready(div_ready), .request(request),
        .core_num(core_num), .order(order), .rs1(rs1), .rs2(rs2),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        core_req  = 4'd0;
        div_ready = 4'd0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        #1;
    endtask

    task automatic set_op(input int n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        core_order[2*n +: 2]  = op;
        core_rs1[32*n +: 32]  = a;
        core_rs2[32*n +: 32]  = b;
    endtask

    task automatic test_reset();
        core_req = 4'hF;
        #1;
        total_cnt++; if (request !== 1'b0) $display("FAIL reset_request got=%0b exp=0", request); else pass_cnt++;
        total_cnt++; if (core_num !== 3'd0) $display("FAIL reset_core_num got=%0d exp=0", core_num); else pass_cnt++;
        total_cnt++; if (rs1 !== 32'd0 || rs2 !== 32'd0 || order !== 2'd0) $display("FAIL reset_data got=%0d/%0d/%0d exp=0/0/0", rs1, rs2, order); else pass_cnt++;
        total_cnt++; if (core_busy !== 4'd0) $display("FAIL reset_busy got=%b exp=0000", core_busy); else pass_cnt++;
        total_cnt++; if (timeout_err !== 4'd0) $display("FAIL reset_err got=%b exp=0000", timeout_err); else pass_cnt++;
        total_cnt++; if (core_ack !== 4'hF) $display("FAIL reset_ack got=%b exp=1111", core_ack); else pass_cnt++;
        core_req = 4'd0;
    endtask

    task automatic test_single_op();
        do_reset();
        set_op(2, 2'b00, 32'd100, 32'd7);
        core_req = 4'b0100;
        #1;
        total_cnt++; if (core_ack !== 4'b0100) $display("FAIL single_ack got=%b exp=0100", core_ack); else pass_cnt++;
        step();
        core_req = 4'd0;
        #1;
        total_cnt++; if (core_busy !== 4'b0100 || request !== 1'b0) $display("FAIL single_held got=%b/%0b exp=0100/0", core_busy, request); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'b010) $display("FAIL single_issue got=%0b/%0d exp=1/2", request, core_num); else pass_cnt++;
        total_cnt++; if (rs1 !== 32'd100 || rs2 !== 32'd7 || order !== 2'b00) $display("FAIL single_data got=%0d/%0d/%0d exp=100/7/0", rs1, rs2, order); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b0 || rs1 !== 32'd100 || core_busy !== 4'b0100) $display("FAIL single_after got=%0b/%0d/%b exp=0/100/0100", request, rs1, core_busy); else pass_cnt++;
        div_ready = 4'b0100;
        step();
        div_ready = 4'd0;
        #1;
        total_cnt++; if (core_busy !== 4'd0) $display("FAIL single_done got=%b exp=0000", core_busy); else pass_cnt++;
    endtask

    task automatic test_contention();
        do_reset();
        for (int n = 0; n < 4; n++) set_op(n, 2'(n), 32'(10 + n), 32'(20 + n));
        core_req = 4'hF;
        #1;
        total_cnt++; if (core_ack !== 4'hF) $display("FAIL cont_ack got=%b exp=1111", core_ack); else pass_cnt++;
        step();
        core_req = 4'd0;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd0 || rs1 !== 32'd10) $display("FAIL cont_g0 got=%0b/%0d/%0d exp=1/0/10", request, core_num, rs1); else pass_cnt++;
        div_ready = 4'b0001;
        step();
        div_ready = 4'd0;
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd1 || rs1 !== 32'd11 || order !== 2'd1) $display("FAIL cont_g1 got=%0b/%0d/%0d/%0d exp=1/1/11/1", request, core_num, rs1, order); else pass_cnt++;
        set_op(0, 2'b11, 32'd50, 32'd5);
        core_req = 4'b0001;
        #1;
        total_cnt++; if (core_ack !== 4'b0001) $display("FAIL cont_refill_ack got=%b exp=0001", core_ack); else pass_cnt++;
        step();
        core_req = 4'd0;
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd2 || rs2 !== 32'd22) $display("FAIL cont_g2 got=%0b/%0d/%0d exp=1/2/22", request, core_num, rs2); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd3 || rs1 !== 32'd13) $display("FAIL cont_g3 got=%0b/%0d/%0d exp=1/3/13", request, core_num, rs1); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd0 || rs1 !== 32'd50 || order !== 2'b11) $display("FAIL cont_refill got=%0b/%0d/%0d/%0d exp=1/0/50/3", request, core_num, rs1, order); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b0) $display("FAIL cont_quiet got=%0b exp=0", request); else pass_cnt++;
        div_ready = 4'hF;
        step();
        div_ready = 4'd0;
    endtask

    task automatic test_one_outstanding();
        do_reset();
        set_op(1, 2'b01, 32'd200, 32'd3);
        core_req = 4'b0010;
        step();
        set_op(1, 2'b10, 32'd201, 32'd4);
        #1;
        total_cnt++; if (core_ack !== 4'd0) $display("FAIL oo_held_ack got=%b exp=0000", core_ack); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd1 || rs1 !== 32'd200) $display("FAIL oo_issue got=%0b/%0d/%0d exp=1/1/200", request, core_num, rs1); else pass_cnt++;
        total_cnt++; if (core_ack !== 4'd0) $display("FAIL oo_issued_ack got=%b exp=0000", core_ack); else pass_cnt++;
        step();
        step();
        total_cnt++; if (request !== 1'b0 || core_ack !== 4'd0) $display("FAIL oo_no_reissue got=%0b/%b exp=0/0000", request, core_ack); else pass_cnt++;
        div_ready = 4'b0010;
        #1;
        total_cnt++; if (core_ack !== 4'd0) $display("FAIL oo_ready_same_cycle got=%b exp=0000", core_ack); else pass_cnt++;
        step();
        div_ready = 4'd0;
        #1;
        total_cnt++; if (core_ack !== 4'b0010) $display("FAIL oo_ack_next got=%b exp=0010", core_ack); else pass_cnt++;
        step();
        core_req = 4'd0;
        step();
        total_cnt++; if (request !== 1'b1 || rs1 !== 32'd201 || order !== 2'b10) $display("FAIL oo_second got=%0b/%0d/%0d exp=1/201/2", request, rs1, order); else pass_cnt++;
        div_ready = 4'b0010;
        step();
        div_ready = 4'd0;
    endtask

    task automatic test_timeout();
        do_reset();
        set_op(3, 2'b01, 32'd300, 32'd9);
        core_req = 4'b1000;
        step();
        core_req = 4'd0;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd3) $display("FAIL to_issue got=%0b/%0d exp=1/3", request, core_num); else pass_cnt++;
        for (int i = 0; i < 30; i++) step();
        total_cnt++; if (core_busy !== 4'b1000 || timeout_err !== 4'd0) $display("FAIL to_waiting got=%b/%b exp=1000/0000", core_busy, timeout_err); else pass_cnt++;
        for (int i = 0; i < 3; i++) step();
        total_cnt++; if (core_busy !== 4'd0 || timeout_err !== 4'b1000) $display("FAIL to_expired got=%b/%b exp=0000/1000", core_busy, timeout_err); else pass_cnt++;
        div_ready = 4'b1000;
        step();
        div_ready = 4'd0;
        total_cnt++; if (core_busy !== 4'd0 || timeout_err !== 4'b1000) $display("FAIL to_late_ready got=%b/%b exp=0000/1000", core_busy, timeout_err); else pass_cnt++;
        core_req = 4'b1000;
        step();
        core_req  = 4'd0;
        div_ready = 4'b1000;
        step();
        div_ready = 4'd0;
        total_cnt++; if (core_busy !== 4'b1000 || request !== 1'b1 || timeout_err !== 4'b1000) $display("FAIL to_held_ready got=%b/%0b/%b exp=1000/1/1000", core_busy, request, timeout_err); else pass_cnt++;
        div_ready = 4'b1000;
        step();
        div_ready = 4'd0;
    endtask

    task automatic test_reset_mid();
        set_op(0, 2'b10, 32'd400, 32'd8);
        set_op(2, 2'b01, 32'd402, 32'd6);
        core_req = 4'b0101;
        step();
        core_req = 4'd0;
        step();
        total_cnt++; if (core_busy !== 4'b0101 || request !== 1'b1 || core_num !== 3'd0) $display("FAIL mid_pre got=%b/%0b/%0d exp=0101/1/0", core_busy, request, core_num); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (core_busy !== 4'd0 || request !== 1'b0 || core_num !== 3'd0) $display("FAIL mid_async got=%b/%0b/%0d exp=0000/0/0", core_busy, request, core_num); else pass_cnt++;
        total_cnt++; if (rs1 !== 32'd0 || order !== 2'd0 || timeout_err !== 4'd0) $display("FAIL mid_async_data got=%0d/%0d/%b exp=0/0/0000", rs1, order, timeout_err); else pass_cnt++;
        step();
        reset = 1'b0;
        div_ready = 4'b0101;
        step();
        div_ready = 4'd0;
        total_cnt++; if (core_busy !== 4'd0) $display("FAIL mid_ready_ignored got=%b exp=0000", core_busy); else pass_cnt++;
        core_req = 4'b0101;
        step();
        core_req = 4'd0;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd0 || rs1 !== 32'd400) $display("FAIL mid_first_grant got=%0b/%0d/%0d exp=1/0/400", request, core_num, rs1); else pass_cnt++;
        step();
        total_cnt++; if (request !== 1'b1 || core_num !== 3'd2 || rs1 !== 32'd402) $display("FAIL mid_second_grant got=%0b/%0d/%0d exp=1/2/402", request, core_num, rs1); else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset      = 1'b1;
        core_req   = 4'd0;
        core_order = 8'd0;
        core_rs1   = 128'd0;
        core_rs2   = 128'd0;
        div_ready  = 4'd0;
        #1;
        test_reset();
        step();
        reset = 1'b0;
        test_single_op();
        test_contention();
        test_one_outstanding();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
